// File: rtl/coh_pkg.sv
// Coherence definitions shared by the MSI and MESI line controllers:
// bus message codes, line states and the snoop transition function.
package coh_pkg;

    localparam logic [2:0] BUS_IDLE = 3'd0;
    localparam logic [2:0] BUS_RD   = 3'd1;
    localparam logic [2:0] BUS_RDX  = 3'd2;
    localparam logic [2:0] BUS_UPGR = 3'd3;

    typedef enum logic [1:0] {
        LS_I = 2'd0,
        LS_S = 2'd1,
        LS_E = 2'd2,
        LS_M = 2'd3
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_BUS   = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    typedef struct packed {
        line_state_e next;
        logic        shared;
        logic        flush;
        logic        err;
    } snoop_resp_t;

    // An MSI line never holds E, so the same function serves both models.
    function automatic snoop_resp_t snoop_next(input line_state_e cur, input logic [2:0] msg);
        snoop_resp_t r;
        r = '{next: cur, shared: 1'b0, flush: 1'b0, err: 1'b0};
        case (msg)
            BUS_IDLE: r.next = cur;
            BUS_RD: begin
                if (cur != LS_I) begin
                    r.next   = LS_S;
                    r.shared = 1'b1;
                    r.flush  = (cur == LS_M);
                end
            end
            BUS_RDX: begin
                r.next  = LS_I;
                r.flush = (cur == LS_M);
            end
            BUS_UPGR: begin
                r.next = LS_I;
                r.err  = (cur == LS_E) || (cur == LS_M);
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mesi_line_array.sv
// Per-line coherence state storage with an own-transaction port and a
// snoop port; each port reads and writes its own line index.
module mesi_line_array
    import coh_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] own_addr_i,
    input  logic              own_we_i,
    input  line_state_e       own_state_i,
    output line_state_e       own_state_o,
    input  logic [ADDR_W-1:0] snp_addr_i,
    input  logic              snp_we_i,
    input  line_state_e       snp_state_i,
    output line_state_e       snp_state_o
);

    localparam int NUM_LINES = 2 ** ADDR_W;

    line_state_e lines_q [NUM_LINES];

    assign own_state_o = lines_q[own_addr_i];
    assign snp_state_o = lines_q[snp_addr_i];

    // The own write comes last so it wins when both ports hit the same line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_q[i] <= LS_I;
            end
        end else begin
            if (snp_we_i) begin
                lines_q[snp_addr_i] <= snp_state_i;
            end
            if (own_we_i) begin
                lines_q[own_addr_i] <= own_state_i;
            end
        end
    end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// MESI per-CPU coherence controller: CPU request port, bus request/grant
// handshake, one-cycle bus issue, and snoop response with error detection.
module mesi_cache_ctrl
    import coh_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int CPU_ID = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_valid_i,
    input  logic              cpu_req_wr_i,
    input  logic [ADDR_W-1:0] cpu_req_addr_i,
    output logic              cpu_req_ready_o,
    output logic              cpu_done_o,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic [2:0]        bus_msg_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic [2:0]        bus_msg_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic              bus_shared_i,
    output logic              shared_o,
    output logic              flush_o,
    output logic              protocol_err_o
);

    ctrl_state_e       state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    line_state_e own_line, snp_line, own_next, snp_next;
    logic        own_we, snp_we, snp_active, snp_apply;
    snoop_resp_t resp;

    mesi_line_array #(.ADDR_W(ADDR_W)) u_lines (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .own_addr_i  (addr_q),
        .own_we_i    (own_we),
        .own_state_i (own_next),
        .own_state_o (own_line),
        .snp_addr_i  (bus_addr_i),
        .snp_we_i    (snp_we),
        .snp_state_i (snp_next),
        .snp_state_o (snp_line)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid_i) begin
                    wr_d    = cpu_req_wr_i;
                    addr_d  = cpu_req_addr_i;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((!wr_q && own_line != LS_I) ||
                    (wr_q && (own_line == LS_E || own_line == LS_M))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ:  state_d = bus_gnt_i ? ST_BUS : ST_REQ;
            ST_BUS:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The line state seen in BUS already reflects any snoop taken during REQ.
    always_comb begin
        cpu_req_ready_o = (state_q == ST_IDLE) && !rst_i;
        cpu_done_o      = (state_q == ST_DONE) && !rst_i;
        bus_req_o       = (state_q == ST_REQ) && !rst_i;
        bus_msg_o       = BUS_IDLE;
        bus_addr_o      = '0;
        own_we          = 1'b0;
        own_next        = own_line;
        if (state_q == ST_CHECK && wr_q && own_line == LS_E) begin
            own_we   = 1'b1;
            own_next = LS_M;
        end
        if (state_q == ST_BUS) begin
            bus_addr_o = addr_q;
            if (!wr_q) begin
                bus_msg_o = BUS_RD;
                if (own_line == LS_I) begin
                    own_we   = 1'b1;
                    own_next = bus_shared_i ? LS_S : LS_E;
                end
            end else begin
                bus_msg_o = (own_line == LS_S) ? BUS_UPGR : BUS_RDX;
                own_we    = 1'b1;
                own_next  = LS_M;
            end
        end

        snp_active = (bus_msg_i != BUS_IDLE);
        resp       = snoop_next(snp_line, bus_msg_i);
        snp_apply  = snp_active && !(state_q == ST_BUS && bus_addr_i == addr_q);
        snp_we     = snp_apply;
        snp_next   = resp.next;
        shared_o   = snp_apply && resp.shared;
        flush_o    = snp_apply && resp.flush;
        err_d      = err_q || (snp_active && (resp.err || state_q == ST_BUS));
        protocol_err_o = err_q;
    end

    a_no_msg_while_req : assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus_req_o && bus_msg_o != BUS_IDLE))
        else $error("mesi_cache_ctrl[%0d]: bus message issued while still requesting", CPU_ID);

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Directed bench for mesi_cache_ctrl: expected bus issues are queued when a
// miss is requested and popped when the controller drives the bus.
module tb_mesi_cache_ctrl;
    import coh_pkg::*;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              cpu_req_valid_i;
    logic              cpu_req_wr_i;
    logic [ADDR_W-1:0] cpu_req_addr_i;
    logic              cpu_req_ready_o;
    logic              cpu_done_o;
    logic              bus_req_o;
    logic              bus_gnt_i;
    logic [2:0]        bus_msg_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [2:0]        bus_msg_i;
    logic [ADDR_W-1:0] bus_addr_i;
    logic              bus_shared_i;
    logic              shared_o;
    logic              flush_o;
    logic              protocol_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] exp_q[$];

    mesi_cache_ctrl #(.ADDR_W(ADDR_W), .CPU_ID(0)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .cpu_req_valid_i (cpu_req_valid_i),
        .cpu_req_wr_i    (cpu_req_wr_i),
        .cpu_req_addr_i  (cpu_req_addr_i),
        .cpu_req_ready_o (cpu_req_ready_o),
        .cpu_done_o      (cpu_done_o),
        .bus_req_o       (bus_req_o),
        .bus_gnt_i       (bus_gnt_i),
        .bus_msg_o       (bus_msg_o),
        .bus_addr_o      (bus_addr_o),
        .bus_msg_i       (bus_msg_i),
        .bus_addr_i      (bus_addr_i),
        .bus_shared_i    (bus_shared_i),
        .shared_o        (shared_o),
        .flush_o         (flush_o),
        .protocol_err_o  (protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Handshake at N, CHECK at N+1; returns positioned at cycle N+2.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a);
        cpu_req_valid_i = 1'b1;
        cpu_req_wr_i    = wr;
        cpu_req_addr_i  = a;
        smp();
        check("ready_at_n", 8'(cpu_req_ready_o), 8'd1);
        step();
        cpu_req_valid_i = 1'b0;
        smp();
        check("check_no_req", 8'(bus_req_o), 8'd0);
        check("check_no_msg", 8'(bus_msg_o), 8'd0);
        step();
    endtask

    // Grant arrives gdly cycles after bus_req_o rises; shared drives the BUS cycle.
    task automatic bus_phase(input int gdly, input logic sh);
        logic [4:0] e;
        for (int i = 0; i < gdly; i++) begin
            smp();
            check("req_hold", 8'(bus_req_o), 8'd1);
            check("req_no_msg", 8'(bus_msg_o), 8'd0);
            step();
        end
        bus_gnt_i = 1'b1;
        smp();
        check("req_at_gnt", 8'(bus_req_o), 8'd1);
        step();
        bus_gnt_i    = 1'b0;
        bus_shared_i = sh;
        smp();
        check("bus_req_low", 8'(bus_req_o), 8'd0);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL bus_issue: observed %0h expected none queued", {bus_msg_o, bus_addr_o});
        end else begin
            e = exp_q.pop_front();
            check("bus_issue", 8'({bus_msg_o, bus_addr_o}), 8'(e));
        end
        step();
        bus_shared_i = 1'b0;
        smp();
        check("done_g2", 8'(cpu_done_o), 8'd1);
        check("done_no_msg", 8'(bus_msg_o), 8'd0);
        step();
        smp();
        check("ready_after", 8'(cpu_req_ready_o), 8'd1);
        step();
    endtask

    task automatic snoop(input logic [2:0] m, input logic [ADDR_W-1:0] a,
                         input logic exp_sh, input logic exp_fl);
        bus_msg_i  = m;
        bus_addr_i = a;
        smp();
        check("snp_shared", 8'(shared_o), 8'(exp_sh));
        check("snp_flush", 8'(flush_o), 8'(exp_fl));
        step();
        bus_msg_i  = BUS_IDLE;
        bus_addr_i = '0;
    endtask

    initial begin
        rst_i           = 1'b1;
        cpu_req_valid_i = 1'b0;
        cpu_req_wr_i    = 1'b0;
        cpu_req_addr_i  = '0;
        bus_gnt_i       = 1'b0;
        bus_msg_i       = BUS_IDLE;
        bus_addr_i      = '0;
        bus_shared_i    = 1'b0;

        // Reset values.
        step();
        smp();
        check("rst_ready_low", 8'(cpu_req_ready_o), 8'd0);
        step();
        rst_i = 1'b0;
        smp();
        check("rst_ready_high", 8'(cpu_req_ready_o), 8'd1);
        check("rst_outputs", 8'({cpu_done_o, bus_req_o, bus_msg_o, shared_o, flush_o, protocol_err_o}), 8'd0);
        check("rst_bus_addr", 8'(bus_addr_o), 8'd0);
        check("rst_line2", 8'(dut.u_lines.lines_q[2]), 8'(LS_I));
        step();

        // Read miss, not shared: E.
        exp_q.push_back({BUS_RD, 2'd2});
        issue(1'b0, 2'd2);
        bus_phase(3, 1'b0);
        check("rd_line2_e", 8'(dut.u_lines.lines_q[2]), 8'(LS_E));

        // BusRdX on E: invalidate, no flush.
        snoop(BUS_RDX, 2'd2, 1'b0, 1'b0);
        check("rdx_line2_i", 8'(dut.u_lines.lines_q[2]), 8'(LS_I));

        // Read miss, shared: S.
        exp_q.push_back({BUS_RD, 2'd2});
        issue(1'b0, 2'd2);
        bus_phase(3, 1'b1);
        check("rd_line2_s", 8'(dut.u_lines.lines_q[2]), 8'(LS_S));

        // Fill line 1 as E, then silent write upgrade.
        exp_q.push_back({BUS_RD, 2'd1});
        issue(1'b0, 2'd1);
        bus_phase(0, 1'b0);
        check("rd_line1_e", 8'(dut.u_lines.lines_q[1]), 8'(LS_E));
        issue(1'b1, 2'd1);
        smp();
        check("e_wr_done", 8'(cpu_done_o), 8'd1);
        check("e_wr_no_req", 8'(bus_req_o), 8'd0);
        step();
        check("e_wr_line1_m", 8'(dut.u_lines.lines_q[1]), 8'(LS_M));
        smp();
        check("e_wr_ready", 8'(cpu_req_ready_o), 8'd1);
        step();

        // Line 3 in S, write; a BusUpgr snoop during REQ turns it into BusRdX.
        exp_q.push_back({BUS_RD, 2'd3});
        issue(1'b0, 2'd3);
        bus_phase(1, 1'b1);
        check("rd_line3_s", 8'(dut.u_lines.lines_q[3]), 8'(LS_S));
        exp_q.push_back({BUS_RDX, 2'd3});
        issue(1'b1, 2'd3);
        bus_msg_i  = BUS_UPGR;
        bus_addr_i = 2'd3;
        smp();
        check("upgr_req_hold", 8'(bus_req_o), 8'd1);
        step();
        bus_msg_i  = BUS_IDLE;
        bus_addr_i = '0;
        check("upgr_line3_i", 8'(dut.u_lines.lines_q[3]), 8'(LS_I));
        check("upgr_no_err", 8'(protocol_err_o), 8'd0);
        bus_phase(1, 1'b0);
        check("rdx_line3_m", 8'(dut.u_lines.lines_q[3]), 8'(LS_M));

        // Line 0 to M via write miss, then snoops.
        exp_q.push_back({BUS_RDX, 2'd0});
        issue(1'b1, 2'd0);
        bus_phase(2, 1'b0);
        check("wr_line0_m", 8'(dut.u_lines.lines_q[0]), 8'(LS_M));
        snoop(BUS_RD, 2'd0, 1'b1, 1'b1);
        check("snp_rd_line0_s", 8'(dut.u_lines.lines_q[0]), 8'(LS_S));
        snoop(BUS_RDX, 2'd0, 1'b0, 1'b0);
        check("snp_rdx_line0_i", 8'(dut.u_lines.lines_q[0]), 8'(LS_I));
        check("no_err_yet", 8'(protocol_err_o), 8'd0);

        // BusUpgr on an M line is a protocol error; flag is sticky.
        snoop(BUS_UPGR, 2'd3, 1'b0, 1'b0);
        check("upgr_m_line3_i", 8'(dut.u_lines.lines_q[3]), 8'(LS_I));
        check("upgr_m_err", 8'(protocol_err_o), 8'd1);
        for (int i = 0; i < 1 + $urandom_range(0, 3); i++) step();
        check("err_sticky", 8'(protocol_err_o), 8'd1);

        // Reset mid-REQ aborts and clears everything.
        issue(1'b0, 2'd3);
        rst_i = 1'b1;
        smp();
        check("midrst_ready_low", 8'(cpu_req_ready_o), 8'd0);
        step();
        rst_i = 1'b0;
        smp();
        check("midrst_ready", 8'(cpu_req_ready_o), 8'd1);
        check("midrst_outputs", 8'({cpu_done_o, bus_req_o, bus_msg_o, shared_o, flush_o, protocol_err_o}), 8'd0);
        check("midrst_state", 8'(dut.state_q), 8'(ST_IDLE));
        check("midrst_line1", 8'(dut.u_lines.lines_q[1]), 8'(LS_I));
        check("midrst_line2", 8'(dut.u_lines.lines_q[2]), 8'(LS_I));
        step();
        smp();
        check("midrst_no_done", 8'(cpu_done_o), 8'd0);
        check("exp_q_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mesi_cache_ctrl.md
# mesi_cache_ctrl

Per-CPU coherence controller for the snooping-bus multiprocessor model, the MESI successor to the MSI line controller. It holds one 2-bit coherence state per line (tag-free, direct address = line index) and serves one CPU read/write at a time through a valid/ready request port. It wins the shared bus through a request/grant handshake with the arbiter, and snoops other masters' transactions. Adds the Exclusive state (silent E->M upgrade), a shared-line response, and protocol-error detection.

## Interface
- `ADDR_W`, 2, line-index width; `NUM_LINES = 2**ADDR_W` is derived.
- `CPU_ID`, 0, instance identifier, used only in assertion messages.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset is synchronous and active-high.
- `cpu_req_valid_i` in 1: CPU request valid.
- `cpu_req_wr_i` in 1: 1 = write, 0 = read.
- `cpu_req_addr_i` in ADDR_W: line index.
- `cpu_req_ready_o` out 1: controller can accept a request.
- `cpu_done_o` out 1: one-cycle pulse when the accepted operation completes.
- `bus_req_o` out 1: bus request to the arbiter.
- `bus_gnt_i` in 1: grant from the arbiter.
- `bus_msg_o` out 3: issued message (0 Idle, 1 BusRd, 2 BusRdX, 3 BusUpgr).
- `bus_addr_o` out ADDR_W: issued line index.
- `bus_msg_i` in 3: snooped message from another master.
- `bus_addr_i` in ADDR_W: snooped line index.
- `bus_shared_i` in 1: wired-OR of the other caches' `shared_o`.
- `shared_o` out 1: this cache holds the snooped BusRd line.
- `flush_o` out 1: this cache supplies or writes back the snooped line (it was M).
- `protocol_err_o` out 1: sticky protocol-error flag.

## Operation
- Line states are I=0, S=1, E=2, M=3. Reset sets every line to I.
- Main FSM states are IDLE, CHECK, REQ, BUS and DONE.
- IDLE
  - `cpu_req_ready_o`=1.
  - On valid&ready, capture wr/addr and go to CHECK.
- CHECK resolves hit or miss against the current line state:
  - Read on S/E/M is a hit: go to DONE.
  - Write on M is a hit: go to DONE.
  - Write on E is a hit: line goes to M at the end of CHECK, then DONE. No bus traffic.
  - Otherwise go to REQ.
- REQ
  - `bus_req_o`=1 until `bus_gnt_i` is sampled high, then go to BUS.
  - `bus_gnt_i` is ignored outside REQ.
- BUS is exactly one cycle. `bus_addr_o` = captured addr. The message is chosen from the line state in this cycle, which covers snoops that landed during REQ:
  - read with line I: BusRd. Next state is S if `bus_shared_i`=1, else E.
  - write with line I: BusRdX. Next state is M.
  - write with line S: BusUpgr. Next state is M.
  - read with line no longer I (cannot occur): BusRd, state unchanged.
- DONE: `cpu_done_o`=1, then go to IDLE.
- Snoop (any state, `bus_msg_i`≠0, applied to line `bus_addr_i`):
  - BusRd:
    - M->S with `flush_o`=1 and `shared_o`=1.
    - E->S with `shared_o`=1.
    - S stays S with `shared_o`=1.
    - I: no response.
  - BusRdX: M->I with `flush_o`=1; S/E->I.
  - BusUpgr:
    - S->I.
    - On E or M: line goes to I and `protocol_err_o` is set (another S copy cannot coexist).
  - `bus_msg_i` > 3: ignored, sets `protocol_err_o`.
  - `bus_msg_i`≠0 during own BUS cycle: the arbiter exclusivity violation sets `protocol_err_o`. The own transaction wins on the own line; the snoop is applied to other lines.
- `shared_o` and `flush_o` are combinational from `bus_msg_i`/`bus_addr_i` and the current state, in the same cycle.
- Snoop and own-transaction state updates are registered at the end of the cycle.
- `protocol_err_o` clears only on reset.

## Timing
- Reset values:
  - FSM in IDLE, all lines I.
  - `cpu_req_ready_o`=0 during the reset cycle and 1 the cycle after.
  - `cpu_done_o`, `bus_req_o`, `bus_msg_o`=0, `bus_addr_o`=0, `shared_o`, `flush_o`, `protocol_err_o` all 0.
- Reset mid-operation aborts the operation: FSM to IDLE, lines to I, no `cpu_done_o`.
- Hit: handshake at cycle N, CHECK at N+1, `cpu_done_o` at N+2, ready again at N+3.
- Miss:
  - CHECK at N+1.
  - `bus_req_o` high from N+2.
  - Grant sampled at cycle G ≥ N+2.
  - BUS at G+1, with `bus_req_o` low and `bus_msg_o` valid.
  - DONE at G+2.
- `bus_msg_o`=0 in every state except BUS.

## Structure
- Shared package `coh_pkg` holds:
  - the bus message constants (Idle/Rd/RdX/Upgr);
  - the line-state enum I/S/E/M;
  - a snoop-next-state function reused by the MSI and MESI models.
- Sub-module `mesi_line_array` holds the `NUM_LINES` state registers. It provides:
  - one own-update write port;
  - one snoop-update write port (own port has priority on an address collision);
  - two read ports (captured addr and `bus_addr_i`).
- The FSM and handshakes stay in the top module.

## Test plan
- Read miss, addr 2, `bus_shared_i`=0, grant 3 cycles after request:
  - BusRd at G+1, line 2 = E;
  - `cpu_done_o` at G+2.
- The same scenario with `bus_shared_i`=1 at BUS: line 2 = S.
- Write to an E line (addr 1): no `bus_req_o`; line 1 = M; `cpu_done_o` at N+2.
- Line 3 in S, write request; snoop BusUpgr on addr 3 during REQ:
  - line goes to I;
  - on grant, `bus_msg_o`=BusRdX (not BusUpgr) and line 3 = M.
- Line 0 in M:
  - snoop BusRd addr 0 gives `flush_o`=1, `shared_o`=1 in the same cycle; line 0 = S.
  - A following BusRdX addr 0 gives line 0 = I with no flush.
- Snoop BusUpgr on an M line gives line = I and `protocol_err_o`=1. The flag stays set until `rst_i` is asserted mid-REQ, which also gives the IDLE, all-I and zero-output reset values.
